mem_arbiter: RTL
================

# mem_arbiter

Two-port memory arbiter that shares the single synchronous RAM port between the CPU controller (requester 0) and the loader/debug port (requester 1). Each access is granted round-robin, latched, issued to RAM as one MREAD/MWRITE cycle and completed with a one-cycle `done` pulse. It sits between the requesters and the RAM, and owns every RAM control signal.

## Interface
- `AW`, default 9: address width.
- `DW`, default 16: data width.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset. Clock is `clk`.
- `req0`, `req1`  in  1  access request; each requester holds it until its `done`.
- `we0`, `we1`  in  1  1 = write, 0 = read; sampled at grant.
- `addr0`, `addr1`  in  AW  word address; sampled at grant.
- `wdata0`, `wdata1`  in  DW  write data; sampled at grant.
- `done0`, `done1`  out  1  one-cycle completion pulse to the granted requester.
- `rdata`  out  DW  read data; valid only while `done0` or `done1` is high after a read.
- `busy`  out  1  high in ACCESS and COMPLETE.
- `mem_cmd`  out  2  MNONE=00, MREAD=01, MWRITE=10.
- `mem_addr`  out  AW  RAM address.
- `mem_din`  out  DW  RAM write data.
- `mem_dout`  in  DW  RAM read data; valid one cycle after MREAD is issued.

## Operation
- States: IDLE, ACCESS, COMPLETE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one `reqN` high: grant N.
  - Both high: grant the requester not granted last. `last` pointer resets to 1, so requester 0 wins the first tie.
  - On grant, latch `gnt`, `we`, `addr` and `wdata` from the winner, update `last`, and go to ACCESS.
- ACCESS:
  - `mem_cmd` = MREAD or MWRITE per the latched `we`; `mem_addr`/`mem_din` come from the latch.
  - Input changes are ignored.
  - Always go to COMPLETE.
- COMPLETE:
  - `mem_cmd` = MNONE.
  - `done[gnt]` = 1. For a read, `rdata` is driven by `mem_dout`.
  - Always go to IDLE.
- Requester rule: after seeing `done`, deassert `req` or present a new request in the next cycle. IDLE re-arbitrates from scratch.
- `rdata` on writes and outside `done`: hold the last read value (registered capture), never X.
- Fairness: with both requests held continuously, grants alternate 0,1,0,1. No requester waits more than one other access.
- Requests are never dropped. A `reqN` arriving while busy is served in a later IDLE.
- Reset mid-operation: return to IDLE next edge, no `done` issued, in-flight write may or may not have reached RAM. Requesters must reissue.
- Reset values:
  - state IDLE, `last`=1, `gnt`=0.
  - `done0`=`done1`=0, `busy`=0, `mem_cmd`=MNONE.
  - `mem_addr`=0, `mem_din`=0, `rdata`=0.

## Timing
- All outputs are registered or decoded from registered state only; no combinational path from `req*` to outputs.
- Latency, request high sampled at edge T in IDLE:
  - ACCESS in cycle T+1.
  - COMPLETE (`done`, `rdata` valid) in cycle T+2.
  - Back in IDLE at T+3.
- Throughput: one access per 3 cycles.
- `mem_cmd` is non-MNONE for exactly one cycle per access. MWRITE is never issued twice for one grant.

## Structure
- Shared package `mem_pkg` holds:
  - `MNONE`/`MREAD`/`MWRITE` localparams (also used by the CPU FSM).
  - State enum `arb_state_t`.
- One sub-module `rr_pick2`: combinational two-way round-robin pick (`req0`, `req1`, `last` -> `grant_valid`, `grant_id`). Top level holds the FSM, latches and `last` register.

## Test plan
- Single read: mem[0x05]=0xBEEF, `req0`=1 `we0`=0 `addr0`=0x05 → MREAD at 0x05 one cycle, `done0`=1 with `rdata`=0xBEEF two cycles after request, `done1` stays 0.
- Single write then read: `req1` write 0x1234 to 0x1FF → MWRITE one cycle with `mem_din`=0x1234; a following `req1` read of 0x1FF returns 0x1234.
- Tie after reset: `req0` and `req1` asserted same cycle → requester 0 served first, requester 1 next; then both held for 6 accesses → grant order 0,1,0,1,0,1.
- Input change during ACCESS: `addr0` changes from 0x10 to 0x20 in ACCESS cycle → `mem_addr` stays 0x10 and the data returned is mem[0x10].
- Reset mid-access: `reset`=1 during ACCESS of a read → next cycle IDLE, `mem_cmd`=MNONE, no `done` pulse, all outputs at reset values.
- Idle hold: no requests for 20 cycles → `mem_cmd`=MNONE, `busy`=0, `rdata` unchanged throughout.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-side definitions: RAM command codes and arbiter states.
// Used by the arbiter and the CPU controller FSM.
package mem_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'b00,
        ARB_ACCESS   = 2'b01,
        ARB_COMPLETE = 2'b10
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the requester not served last wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant_valid,
    output logic grant_id
);

    assign grant_valid = req0 | req1;
    assign grant_id    = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single synchronous RAM port between the CPU (0) and loader (1).
// Each grant issues exactly one RAM command and ends with a one-cycle done.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    arb_state_t    state_q;
    logic          last_q;
    logic          gnt_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic [1:0]    cmd_q;
    logic [1:0]    done_q;

    logic          pick_valid;
    logic          pick_id;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    rr_pick2 u_pick (
        .req0        (req0),
        .req1        (req1),
        .last        (last_q),
        .grant_valid (pick_valid),
        .grant_id    (pick_id)
    );

    assign sel_we    = pick_id ? we1    : we0;
    assign sel_addr  = pick_id ? addr1  : addr0;
    assign sel_wdata = pick_id ? wdata1 : wdata0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cmd_q   <= MNONE;
            done_q  <= 2'b00;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        gnt_q   <= pick_id;
                        last_q  <= pick_id;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        cmd_q   <= sel_we ? MWRITE : MREAD;
                        state_q <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    cmd_q   <= MNONE;
                    done_q  <= gnt_q ? 2'b10 : 2'b01;
                    state_q <= ARB_COMPLETE;
                end
                ARB_COMPLETE: begin
                    done_q  <= 2'b00;
                    // keep the last read value visible once done drops
                    if (!we_q) begin
                        rdata_q <= mem_dout;
                    end
                    state_q <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign done0    = done_q[0];
    assign done1    = done_q[1];
    assign busy     = (state_q != ARB_IDLE);
    assign mem_cmd  = cmd_q;
    assign mem_addr = addr_q;
    assign mem_din  = wdata_q;
    assign rdata    = ((done_q != 2'b00) && !we_q) ? mem_dout : rdata_q;

endmodule
